// File: rtl/wb_mst_pkg.sv
// Shared definitions for the Wishbone command master: bus widths, timeout defaults, FSM states.
package wb_mst_pkg;

    localparam int unsigned WB_ADDR_W = 17;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_STB_W  = WB_DATA_W / 8;
    localparam int unsigned TMO_CNT_W = 8;

    localparam logic [TMO_CNT_W-1:0] TMO_CYCLES_DEF     = 8'd255;
    localparam logic [WB_DATA_W-1:0] TMO_READ_VALUE_DEF = 32'hBAD_FAB_AC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } mst_state_e;

endpackage

// File: rtl/wb_mst_timeout_cntr.sv
// ACK-wait counter: cleared per transaction, counts while enabled, saturates at LIMIT.
module wb_mst_timeout_cntr #(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  LIMIT = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [WIDTH-1:0] count_q;

    // Holding at LIMIT keeps the expired flag sticky and prevents wrap-around.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != LIMIT)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign expired_c = (count_q == LIMIT);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one outstanding single read/write per command, with ACK timeout
// and a valid/ready response port.
module wb_cmd_master
    import wb_mst_pkg::*;
#(
    parameter int unsigned                      ADDRWIDTH          = WB_ADDR_W,
    parameter int unsigned                      DATAWIDTH          = WB_DATA_W,
    parameter int unsigned                      TIMEOUT_CNTR_WIDTH = TMO_CNT_W,
    parameter logic [TIMEOUT_CNTR_WIDTH-1:0]    TIMEOUT_CYCLES     = TIMEOUT_CNTR_WIDTH'(TMO_CYCLES_DEF),
    parameter logic [DATAWIDTH-1:0]             TIMEOUT_READ_VALUE = DATAWIDTH'(TMO_READ_VALUE_DEF)
) (
    input  logic                     WB_CLK,
    input  logic                     WB_RST,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [ADDRWIDTH-1:0]     cmd_adr_i,
    input  logic [DATAWIDTH/8-1:0]   cmd_byte_stb_i,
    input  logic [DATAWIDTH-1:0]     cmd_dat_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DATAWIDTH-1:0]     rsp_dat_o,
    output logic                     rsp_err_o,
    output logic [ADDRWIDTH-1:0]     WBs_ADR,
    output logic                     WBs_CYC,
    output logic                     WBs_STB,
    output logic                     WBs_WE,
    output logic                     WBs_RD,
    output logic [DATAWIDTH/8-1:0]   WBs_BYTE_STB,
    output logic [DATAWIDTH-1:0]     WBs_WR_DAT,
    input  logic [DATAWIDTH-1:0]     WBs_RD_DAT,
    input  logic                     WBs_ACK
);

    localparam int unsigned STB_W = DATAWIDTH / 8;

    mst_state_e state_q, state_d;

    logic                 cmd_ready_q, cmd_ready_d;
    logic                 cyc_q,       cyc_d;
    logic                 rd_q,        rd_d;
    logic                 we_q,        we_d;
    logic [ADDRWIDTH-1:0] adr_q,       adr_d;
    logic [STB_W-1:0]     stb_q,       stb_d;
    logic [DATAWIDTH-1:0] wdat_q,      wdat_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0] rsp_dat_q,   rsp_dat_d;
    logic                 rsp_err_q,   rsp_err_d;

    logic cnt_clr;
    logic cnt_en;
    logic tmo_expired_c;

    wb_mst_timeout_cntr #(
        .WIDTH (TIMEOUT_CNTR_WIDTH),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cntr (
        .clk       (WB_CLK),
        .rst       (WB_RST),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .expired_c (tmo_expired_c)
    );

    // State and all registered outputs; reset drops any in-flight cycle without a response.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            stb_q       <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            stb_q       <= stb_d;
            wdat_q      <= wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        rd_d        = rd_q;
        we_d        = we_q;
        adr_d       = adr_q;
        stb_d       = stb_q;
        wdat_d      = wdat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    rd_d        = ~cmd_we_i;
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    stb_d       = cmd_byte_stb_i;
                    wdat_d      = cmd_dat_i;
                    cnt_clr     = 1'b1;
                    state_d     = BUS;
                end
            end

            BUS: begin
                // An ACK arriving on the abort cycle still completes normally.
                if (WBs_ACK || tmo_expired_c) begin
                    cyc_d       = 1'b0;
                    rd_d        = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    stb_d       = '0;
                    wdat_d      = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                    if (WBs_ACK) begin
                        rsp_dat_d = we_q ? '0 : WBs_RD_DAT;
                        rsp_err_d = 1'b0;
                    end else begin
                        rsp_dat_d = TIMEOUT_READ_VALUE;
                        rsp_err_d = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign WBs_CYC      = cyc_q;
    assign WBs_STB      = cyc_q;
    assign WBs_RD       = rd_q;
    assign WBs_WE       = we_q;
    assign WBs_ADR      = adr_q;
    assign WBs_BYTE_STB = stb_q;
    assign WBs_WR_DAT   = wdat_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
